output_reorder_ctrl: RTL and testbench
======================================

Name: output_reorder_ctrl

Overview:
- In-order retirement controller for the output ring buffer of a multi-stage skipping pipeline.
- Allocates buffer slots (tags) in issue order and accepts out-of-order completions by tag.
- Releases entries to the downstream consumer strictly in issue order.
- Includes a drain sequencer that blocks new issues until all in-flight entries have retired.

Parameters:
- NUM_ENTRY, 4, number of buffer slots; any value >= 2, power of two not required.
- WIDTH_TAG, $clog2(NUM_ENTRY), tag/address width (derived, not overridden).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- I_Clr  in  1  synchronous clear of all state
- I_Issue  in  1  request to allocate a slot
- O_Issue_Ack  out  1  allocation accepted this cycle
- O_WTag  out  WIDTH_TAG  tag allocated (buffer write address at issue)
- I_Cmpl  in  1  completion strobe
- I_Cmpl_Tag  in  WIDTH_TAG  tag of completing entry
- O_Cmpl_Err  out  1  completion to a non-allocated or already-complete tag
- O_Retire  out  1  head entry complete and presented
- O_RTag  out  WIDTH_TAG  head tag (buffer read address)
- I_Retire_Rdy  in  1  consumer accepts head
- I_Drain  in  1  drain request (level, sampled in ST_RUN)
- O_Drained  out  1  one-cycle pulse when drain finishes
- O_Count  out  WIDTH_TAG+1  occupied entries
- O_Full  out  1  O_Count == NUM_ENTRY
- O_Empty  out  1  O_Count == 0

Behaviour:
- Reset or I_Clr (equal effect, highest priority): pointers = 0, count = 0, all valid bits = 0, FSM = ST_RUN. All outputs read 0 except O_Empty = 1.
- Pointers:
  - Write and read pointers increment modulo NUM_ENTRY, wrapping explicitly from NUM_ENTRY-1 to 0.
  - Tags >= NUM_ENTRY are never produced.
- Issue:
  - O_Issue_Ack = I_Issue & ~O_Full & (state == ST_RUN), combinational.
  - O_WTag = write pointer.
  - On ack: allocated bit of the slot is set and the write pointer advances next edge.
- Completion:
  - Accepted when I_Cmpl is high, the tag is allocated, and its done bit is 0. The done bit is set at the next edge.
  - Otherwise O_Cmpl_Err is registered high for one cycle and state is unchanged.
  - A completion to the tag being acked in the same cycle is an error, because the check uses pre-edge state.
- Retire:
  - O_Retire = ~O_Empty & done[read pointer], derived from registered state only.
  - A completion to the head becomes visible on O_Retire one cycle later.
  - Handshake fires when O_Retire & I_Retire_Rdy: the slot's allocated and done bits are cleared and the read pointer advances.
  - O_Retire/O_RTag hold stable while I_Retire_Rdy is low.
- Count: +1 on ack, -1 on retire, unchanged when both occur in the same cycle.
- Full: O_Full uses pre-edge count. With full and a retire in the same cycle, the issue is still rejected.
- FSM:
  - ST_RUN: I_Drain high -> ST_DRAIN.
  - ST_DRAIN: issue blocked; retire and completion continue. When O_Empty -> ST_DONE. If already empty on entry, ST_DONE follows the next cycle.
  - ST_DONE: O_Drained = 1 for exactly one cycle, then -> ST_RUN. I_Drain is ignored until back in ST_RUN.
- Latency: issue-to-tag 0 cycles; completion-to-retire-eligible 1 cycle; retire-to-slot-reusable 1 cycle.
- No combinational path from I_Cmpl or I_Cmpl_Tag to O_Retire.

Test Plan (NUM_ENTRY=4 unless noted):
- Reset then issue x4 -> O_WTag 0,1,2,3 with acks; O_Full=1, O_Count=4; 5th issue gives O_Issue_Ack=0.
- Complete tags 2,0,3,1 with I_Retire_Rdy=1 -> retires in order 0 (cycle after cmpl 0), then 1,2,3 back-to-back after cmpl 1; O_Empty=1 after.
- Full, head complete, I_Issue & I_Retire_Rdy same cycle -> retire occurs, issue rejected, O_Count=3; next cycle issue acks tag 0 (wrap).
- Completion to unallocated tag 1 and a double completion of tag 0 -> O_Cmpl_Err pulses each; valid bits unchanged.
- NUM_ENTRY=3: 7 issue/retire pairs -> tags 0,1,2,0,1,2,0; never 3.
- 2 entries in flight, I_Drain=1 -> issue blocked; after both complete and retire, O_Drained pulses 1 cycle, then issue acks again.
- Mid-traffic I_Clr (and separately reset) -> next cycle O_Empty=1, O_Count=0, next ack tag 0.

Source files
------------

// File: rtl/output_reorder_ctrl.sv
// In-order retirement controller for an output ring buffer: allocates tags in issue order,
// accepts out-of-order completions by tag, and releases entries strictly in issue order.
module output_reorder_ctrl #(
  parameter int unsigned NUM_ENTRY = 4,
  localparam int unsigned WIDTH_TAG = $clog2(NUM_ENTRY)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Clr,
  input  logic                 I_Issue,
  output logic                 O_Issue_Ack,
  output logic [WIDTH_TAG-1:0] O_WTag,
  input  logic                 I_Cmpl,
  input  logic [WIDTH_TAG-1:0] I_Cmpl_Tag,
  output logic                 O_Cmpl_Err,
  output logic                 O_Retire,
  output logic [WIDTH_TAG-1:0] O_RTag,
  input  logic                 I_Retire_Rdy,
  input  logic                 I_Drain,
  output logic                 O_Drained,
  output logic [WIDTH_TAG:0]   O_Count,
  output logic                 O_Full,
  output logic                 O_Empty
);

  // Status bits cover every encodable tag; slots >= NUM_ENTRY are never allocated, so a
  // completion to such a tag always reports an error without a separate range check.
  localparam int unsigned NumSlot = 2 ** WIDTH_TAG;
  localparam logic [WIDTH_TAG-1:0] LastTag = WIDTH_TAG'(NUM_ENTRY - 1);
  localparam logic [WIDTH_TAG:0] FullCount = (WIDTH_TAG + 1)'(NUM_ENTRY);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH_TAG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH_TAG:0]   count_q, count_d;
  logic [NumSlot-1:0]   alloc_q, alloc_d, done_q, done_d;
  logic                 cmpl_err_q, cmpl_err_d;
  logic                 cmpl_ok, retire_fire;

  assign O_Count     = count_q;
  assign O_Full      = (count_q == FullCount);
  assign O_Empty     = (count_q == '0);
  assign O_Issue_Ack = I_Issue & ~O_Full & (state_q == StRun);
  assign O_WTag      = wr_ptr_q;
  assign O_RTag      = rd_ptr_q;
  assign O_Retire    = ~O_Empty & done_q[rd_ptr_q];
  assign O_Cmpl_Err  = cmpl_err_q;
  assign O_Drained   = (state_q == StDone);

  assign retire_fire = O_Retire & I_Retire_Rdy;
  // Uses pre-edge bits, so completing the tag acked in the same cycle is rejected.
  assign cmpl_ok     = I_Cmpl & alloc_q[I_Cmpl_Tag] & ~done_q[I_Cmpl_Tag];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    alloc_d    = alloc_q;
    done_d     = done_q;
    cmpl_err_d = I_Cmpl & ~cmpl_ok;
    state_d    = state_q;

    if (O_Issue_Ack) begin
      alloc_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == LastTag) ? '0 : wr_ptr_q + WIDTH_TAG'(1);
    end
    if (cmpl_ok) begin
      done_d[I_Cmpl_Tag] = 1'b1;
    end
    if (retire_fire) begin
      alloc_d[rd_ptr_q] = 1'b0;
      done_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d = (rd_ptr_q == LastTag) ? '0 : rd_ptr_q + WIDTH_TAG'(1);
    end

    unique case ({O_Issue_Ack, retire_fire})
      2'b10:   count_d = count_q + (WIDTH_TAG + 1)'(1);
      2'b01:   count_d = count_q - (WIDTH_TAG + 1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StRun:   if (I_Drain) state_d = StDrain;
      StDrain: if (O_Empty) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || I_Clr) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alloc_q    <= '0;
      done_q     <= '0;
      cmpl_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      alloc_q    <= alloc_d;
      done_q     <= done_d;
      cmpl_err_q <= cmpl_err_d;
    end
  end

endmodule

// File: tb/tb_output_reorder_ctrl.sv
// Bench for output_reorder_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_output_reorder_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // NUM_ENTRY = 4 instance
  logic       reset, I_Clr, I_Issue, I_Cmpl, I_Retire_Rdy, I_Drain;
  logic [1:0] I_Cmpl_Tag;
  logic       O_Issue_Ack, O_Cmpl_Err, O_Retire, O_Drained, O_Full, O_Empty;
  logic [1:0] O_WTag, O_RTag;
  logic [2:0] O_Count;

  // NUM_ENTRY = 3 instance
  logic       reset_3, clr_3, issue_3, cmpl_3, rdy_3, drain_3;
  logic [1:0] cmpl_tag_3;
  logic       ack_3, err_3, retire_3, drained_3, full_3, empty_3;
  logic [1:0] wtag_3, rtag_3;
  logic [2:0] count_3;

  output_reorder_ctrl #(.NUM_ENTRY(4)) dut (
    .clock(clock), .reset(reset), .I_Clr(I_Clr), .I_Issue(I_Issue),
    .O_Issue_Ack(O_Issue_Ack), .O_WTag(O_WTag), .I_Cmpl(I_Cmpl), .I_Cmpl_Tag(I_Cmpl_Tag),
    .O_Cmpl_Err(O_Cmpl_Err), .O_Retire(O_Retire), .O_RTag(O_RTag),
    .I_Retire_Rdy(I_Retire_Rdy), .I_Drain(I_Drain), .O_Drained(O_Drained),
    .O_Count(O_Count), .O_Full(O_Full), .O_Empty(O_Empty)
  );

  output_reorder_ctrl #(.NUM_ENTRY(3)) dut3 (
    .clock(clock), .reset(reset_3), .I_Clr(clr_3), .I_Issue(issue_3),
    .O_Issue_Ack(ack_3), .O_WTag(wtag_3), .I_Cmpl(cmpl_3), .I_Cmpl_Tag(cmpl_tag_3),
    .O_Cmpl_Err(err_3), .O_Retire(retire_3), .O_RTag(rtag_3),
    .I_Retire_Rdy(rdy_3), .I_Drain(drain_3), .O_Drained(drained_3),
    .O_Count(count_3), .O_Full(full_3), .O_Empty(empty_3)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight tags in issue order plus per-tag completion flags.
  int fl[$];
  bit m_done[4];
  int m_wtag = 0;
  int m_mode = 0;  // 0 running, 1 draining, 2 drained pulse
  bit m_err  = 1'b0;

  always @(negedge clock) begin
    int  cnt, t, ertag;
    bit  efull, eempty, eack, eret, inq, ok;
    cnt    = fl.size();
    efull  = (cnt == 4);
    eempty = (cnt == 0);
    eack   = I_Issue && !efull && (m_mode == 0);
    eret   = !eempty && m_done[fl[0]];
    ertag  = eempty ? m_wtag : fl[0];
    if (chk_en) begin
      chk("ack", int'(O_Issue_Ack), int'(eack));
      chk("wtag", int'(O_WTag), m_wtag);
      chk("retire", int'(O_Retire), int'(eret));
      chk("rtag", int'(O_RTag), ertag);
      chk("count", int'(O_Count), cnt);
      chk("full", int'(O_Full), int'(efull));
      chk("empty", int'(O_Empty), int'(eempty));
      chk("cmpl_err", int'(O_Cmpl_Err), int'(m_err));
      chk("drained", int'(O_Drained), int'(m_mode == 2));
    end
    t   = int'(I_Cmpl_Tag);
    inq = 1'b0;
    foreach (fl[i]) if (fl[i] == t) inq = 1'b1;
    ok = I_Cmpl && inq && !m_done[t];
    if (reset || I_Clr) begin
      fl.delete();
      foreach (m_done[i]) m_done[i] = 1'b0;
      m_wtag = 0;
      m_mode = 0;
      m_err  = 1'b0;
    end else begin
      m_err = I_Cmpl && !ok;
      if (eret && I_Retire_Rdy) begin
        m_done[fl[0]] = 1'b0;
        void'(fl.pop_front());
      end
      if (ok) m_done[t] = 1'b1;
      if (eack) begin
        fl.push_back(m_wtag);
        m_wtag = (m_wtag + 1) % 4;
      end
      case (m_mode)
        0:       if (I_Drain) m_mode = 1;
        1:       if (eempty) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; I_Clr = 0; I_Issue = 0; I_Cmpl = 0; I_Cmpl_Tag = 0;
    I_Retire_Rdy = 0; I_Drain = 0;
  endtask

  task automatic cmpl(input int tag);
    I_Cmpl = 1; I_Cmpl_Tag = 2'(tag);
  endtask

  int exp3[7] = '{0, 1, 2, 0, 1, 2, 0};
  int order[4] = '{2, 0, 3, 1};
  int pi_tab[4] = '{80, 30, 60, 90};
  int pr_tab[4] = '{30, 90, 60, 10};

  initial begin
    idle();
    reset = 1;
    reset_3 = 1; clr_3 = 0; issue_3 = 0; cmpl_3 = 0; cmpl_tag_3 = 0; rdy_3 = 0; drain_3 = 0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 0; reset_3 = 0;

    // Reset state
    chk("rst_empty", int'(O_Empty), 1);
    chk("rst_count", int'(O_Count), 0);
    chk("rst_retire", int'(O_Retire), 0);
    chk("rst_wtag", int'(O_WTag), 0);

    // Fill: tags 0..3, then full rejects
    for (int i = 0; i < 4; i++) begin
      I_Issue = 1; #1;
      chk("fill_ack", int'(O_Issue_Ack), 1);
      chk("fill_wtag", int'(O_WTag), i);
      tick();
    end
    #1;
    chk("full_flag", int'(O_Full), 1);
    chk("full_count", int'(O_Count), 4);
    chk("full_reject", int'(O_Issue_Ack), 0);
    tick();
    idle();

    // Out-of-order completion 2,0,3,1 with consumer always ready
    I_Retire_Rdy = 1;
    for (int i = 0; i < 4; i++) begin
      cmpl(order[i]);
      tick();
      if (i == 0) chk("ooo_hold", int'(O_Retire), 0);
      if (i == 1) begin
        chk("ooo_r0", int'(O_Retire), 1);
        chk("ooo_r0_tag", int'(O_RTag), 0);
      end
      if (i == 2) chk("ooo_wait1", int'(O_Retire), 0);
    end
    I_Cmpl = 0;
    for (int i = 1; i < 4; i++) begin
      chk("ooo_seq_ret", int'(O_Retire), 1);
      chk("ooo_seq_tag", int'(O_RTag), i);
      tick();
    end
    chk("ooo_empty", int'(O_Empty), 1);
    idle();

    // Full with head complete: retire happens, simultaneous issue rejected
    I_Issue = 1;
    repeat (4) tick();
    I_Issue = 0; cmpl(0);
    tick();
    I_Cmpl = 0; I_Issue = 1; I_Retire_Rdy = 1; #1;
    chk("fullret_ack", int'(O_Issue_Ack), 0);
    chk("fullret_ret", int'(O_Retire), 1);
    tick();
    I_Retire_Rdy = 0;
    chk("fullret_count", int'(O_Count), 3);
    #1;
    chk("wrap_ack", int'(O_Issue_Ack), 1);
    chk("wrap_tag", int'(O_WTag), 0);
    tick();
    idle();

    // Clear, then completion errors
    I_Clr = 1;
    tick();
    I_Clr = 0;
    chk("clr_empty", int'(O_Empty), 1);
    chk("clr_count", int'(O_Count), 0);
    I_Issue = 1;
    tick();
    I_Issue = 0; cmpl(1);
    tick();
    chk("err_unalloc", int'(O_Cmpl_Err), 1);
    chk("err_unalloc_ret", int'(O_Retire), 0);
    cmpl(0);
    tick();
    chk("err_ok", int'(O_Cmpl_Err), 0);
    chk("err_ok_ret", int'(O_Retire), 1);
    cmpl(0);
    tick();
    chk("err_double", int'(O_Cmpl_Err), 1);
    chk("err_double_cnt", int'(O_Count), 1);
    I_Issue = 1; cmpl(1);
    tick();
    chk("err_same_cycle", int'(O_Cmpl_Err), 1);
    idle();
    tick();
    chk("err_clear", int'(O_Cmpl_Err), 0);

    // Drain
    I_Clr = 1;
    tick();
    I_Clr = 0; I_Issue = 1;
    repeat (2) tick();
    I_Issue = 0; I_Drain = 1;
    tick();
    I_Drain = 0; I_Issue = 1; #1;
    chk("drain_block", int'(O_Issue_Ack), 0);
    I_Issue = 0; cmpl(0);
    tick();
    cmpl(1); I_Retire_Rdy = 1;
    tick();
    I_Cmpl = 0;
    for (int i = 0; i < 10 && !O_Drained; i++) tick();
    chk("drained_seen", int'(O_Drained), 1);
    tick();
    chk("drained_pulse", int'(O_Drained), 0);
    I_Issue = 1; #1;
    chk("drain_resume", int'(O_Issue_Ack), 1);
    chk("drain_resume_tag", int'(O_WTag), 2);
    tick();
    idle();

    // Reset mid-traffic
    I_Issue = 1;
    tick();
    I_Issue = 0; reset = 1;
    tick();
    reset = 0;
    chk("mrst_empty", int'(O_Empty), 1);
    chk("mrst_count", int'(O_Count), 0);
    I_Issue = 1; #1;
    chk("mrst_tag", int'(O_WTag), 0);
    tick();
    idle();

    // NUM_ENTRY = 3: tags wrap 2 -> 0 and never reach 3
    for (int i = 0; i < 7; i++) begin
      issue_3 = 1; #1;
      chk("n3_ack", int'(ack_3), 1);
      chk("n3_wtag", int'(wtag_3), exp3[i]);
      tick();
      issue_3 = 0; cmpl_3 = 1; cmpl_tag_3 = 2'(exp3[i]);
      tick();
      cmpl_3 = 0; rdy_3 = 1; #1;
      chk("n3_ret", int'(retire_3), 1);
      chk("n3_rtag", int'(rtag_3), exp3[i]);
      tick();
      rdy_3 = 0;
    end
    cmpl_3 = 1; cmpl_tag_3 = 2'd3;
    tick();
    cmpl_3 = 0;
    chk("n3_tag3_err", int'(err_3), 1);
    chk("n3_empty", int'(empty_3), 1);

    // Randomized traffic against the model
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        reset        = ($urandom % 400) == 0;
        I_Clr        = ($urandom % 200) == 0;
        I_Issue      = ($urandom % 100) < pi_tab[ph];
        I_Cmpl       = ($urandom % 100) < 60;
        if (($urandom % 4) != 0 && fl.size() > 0)
          I_Cmpl_Tag = 2'(fl[$urandom % fl.size()]);
        else
          I_Cmpl_Tag = 2'($urandom % 4);
        I_Retire_Rdy = ($urandom % 100) < pr_tab[ph];
        I_Drain      = ($urandom % 50) == 0;
        tick();
      end
    end
    idle();
    tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
